// File: rtl/demux4_stream_pkg.sv
// -----------------------------------------------------------------------------
// demux4_stream_pkg
//   Shared constants and helpers for the 1-to-4 stream distributor.
//   NLANES : number of output lanes
//   onehot4: true when exactly one bit of a 4-bit select is set
// -----------------------------------------------------------------------------
package demux4_stream_pkg;

    localparam int NLANES = 4;

    // Clearing the lowest set bit leaves zero only for a single-bit value;
    // the non-zero test rejects the all-zero select.
    function automatic logic onehot4(input logic [NLANES-1:0] v);
        return (v != '0) && ((v & (v - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/demux4_skid.sv
// -----------------------------------------------------------------------------
// demux4_skid
//   2-entry valid/ready FIFO used as the per-lane skid buffer.
//   clk      : clock, all state on posedge
//   reset    : synchronous active-high reset, empties the buffer
//   wr_valid : write strobe (ignored while full)
//   wr_data  : write payload
//   full     : registered full flag (2 entries held)
//   rd_valid : head entry present
//   rd_data  : head entry payload
//   rd_ready : consumer takes the head when rd_valid is also high
// -----------------------------------------------------------------------------
module demux4_skid #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          wr_en;
    logic          rd_en;

    assign full     = (count == 2'd2);
    assign rd_valid = (count != 2'd0);
    assign rd_data  = mem[rd_ptr];

    assign wr_en = wr_valid & ~full;
    assign rd_en = rd_valid & rd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the two storage words are reset too, so the lane output
            // reads zero after reset instead of leftover payload.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so simultaneous read and write stay consistent.
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end

endmodule

// File: rtl/demux4_stream.sv
// -----------------------------------------------------------------------------
// demux4_stream
//   1-to-4 stream distributor. Each input beat carries a one-hot lane select
//   and is steered into that lane's 2-entry skid buffer. Illegal selects are
//   consumed, dropped and counted.
//   clk       : clock
//   reset     : synchronous active-high reset
//   in_valid  : input beat valid
//   in_sel    : one-hot destination lane
//   in_data   : input payload
//   in_ready  : input accepted when in_valid & in_ready
//   out_valid : per-lane output valid
//   out_data  : lane i payload at [i*DW +: DW]
//   out_ready : per-lane consumer ready
//   err       : sticky illegal-select flag
//   err_count : saturating count of dropped illegal beats
// -----------------------------------------------------------------------------
module demux4_stream
    import demux4_stream_pkg::*;
#(
    parameter int DW   = 32,
    parameter int ERRW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [NLANES-1:0]    in_sel,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic [NLANES-1:0]    out_valid,
    output logic [NLANES*DW-1:0] out_data,
    input  logic [NLANES-1:0]    out_ready,
    output logic                 err,
    output logic [ERRW-1:0]      err_count
);

    logic              legal;
    logic [NLANES-1:0] lane_full;
    logic [NLANES-1:0] lane_wr;

    assign legal = onehot4(in_sel);

    // in_ready comes only from registered full flags and in_sel, never from
    // out_ready, so the producer sees no combinational path from consumers.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        in_ready = 1'b1;
        lane_wr  = '0;
        if (legal) begin
            in_ready = ~|(in_sel & lane_full);
            lane_wr  = {NLANES{in_valid}} & in_sel & ~lane_full;
        end
    end

    // An illegal beat is always accepted and discarded; no lane is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (in_valid && !legal) begin
            err <= 1'b1;
            if (err_count != '1) begin
                err_count <= err_count + ERRW'(1);
            end
        end
    end

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        demux4_skid #(.DW(DW)) u_skid (
            .clk      (clk),
            .reset    (reset),
            .wr_valid (lane_wr[i]),
            .wr_data  (in_data),
            .full     (lane_full[i]),
            .rd_valid (out_valid[i]),
            .rd_data  (out_data[i*DW +: DW]),
            .rd_ready (out_ready[i])
        );
    end

endmodule
